// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encodings and threshold constants for the switch debouncer
package debounce_pkg;

  // Bit 1 of the encoding is the accepted output level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } deb_state_t;

  localparam int DEF_STABLE_CNT  = 50000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Threshold used when the fast-simulation build is selected.
  localparam int SIM_FAST_THRESH = 4;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one debounce channel (synchroniser, 4-state FSM, stability counter); honours DEBOUNCE_SIM_FAST_EN
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef DEBOUNCE_SIM_FAST_EN
  localparam int THRESH = SIM_FAST_THRESH;
`else
  localparam int THRESH = STABLE_CNT;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: raw enters at bit 0, the FSM only looks at the last stage.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // FSM, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: a new level must be seen THRESH consecutive times in WAIT before acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/switch_debounce_2ch.sv
// rtl/switch_debounce_2ch.sv - two independent debounce channels feeding gate inputs a/b; honours DEBOUNCE_SIM_FAST_EN
module switch_debounce_2ch
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic inp_a,
  output logic inp_b,
  output logic rise_a,
  output logic fall_a,
  output logic rise_b,
  output logic fall_b
);

  debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) deb_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_a),
    .level(inp_a),
    .rise (rise_a),
    .fall (fall_a)
  );

  debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) deb_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_b),
    .level(inp_b),
    .rise (rise_b),
    .fall (fall_b)
  );

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// tb/tb_switch_debounce_2ch.sv - directed self-checking bench for switch_debounce_2ch
module tb_switch_debounce_2ch;

  localparam int SYNC_STAGES = 2;
  localparam int STABLE_CNT  = 8;
  localparam int CNT_W       = 16;

  // Output vector bit order: {inp_a, rise_a, fall_a, inp_b, rise_b, fall_b}
  localparam logic [5:0] V_IDLE  = 6'b000_000;
  localparam logic [5:0] V_A_HI  = 6'b100_000;
  localparam logic [5:0] V_A_RS  = 6'b110_000;
  localparam logic [5:0] V_A_FL  = 6'b001_000;
  localparam logic [5:0] V_AB_HI = 6'b100_100;
  localparam logic [5:0] V_AB_RS = 6'b110_110;
  localparam logic [5:0] V_AF_BH = 6'b001_100;
  localparam logic [5:0] V_B_HI  = 6'b000_100;
  localparam logic [5:0] V_B_FL  = 6'b000_001;

  logic clk = 1'b0;
  logic rst, raw_a, raw_b;
  logic inp_a, inp_b, rise_a, fall_a, rise_b, fall_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_debounce_2ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .inp_a (inp_a),
    .inp_b (inp_b),
    .rise_a(rise_a),
    .fall_a(fall_a),
    .rise_b(rise_b),
    .fall_b(fall_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance n rising edges; after each one compare the output vector with exp.
  task automatic step(input string tag, input int n, input logic [5:0] exp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(tag, {26'd0, inp_a, rise_a, fall_a, inp_b, rise_b, fall_b}, {26'd0, exp});
    end
  endtask

  initial begin
    rst   = 1'b1;
    raw_a = 1'b1;
    raw_b = 1'b0;

    // 1. Reset with raw_a held high, then acceptance 10 edges after release.
    step("reset_hold", 3, V_IDLE);
    rst = 1'b0;
    step("rst_rel_wait", 10, V_IDLE);
    step("rst_rel_rise", 1, V_A_RS);
    step("rst_rel_hold", 1, V_A_HI);

    // 2. Clean release, press held 20 cycles, release.
    raw_a = 1'b0;
    step("rel1_wait", 10, V_A_HI);
    step("rel1_fall", 1, V_A_FL);
    step("rel1_idle", 2, V_IDLE);
    raw_a = 1'b1;
    step("press_wait", 10, V_IDLE);
    step("press_rise", 1, V_A_RS);
    step("press_hold", 9, V_A_HI);
    raw_a = 1'b0;
    step("rel2_wait", 10, V_A_HI);
    step("rel2_fall", 1, V_A_FL);
    step("rel2_idle", 2, V_IDLE);

    // 3. Bounce every 3 cycles for 30 cycles, then settle high.
    for (int k = 0; k < 10; k++) begin
      raw_a = (k % 2 == 0);
      step("bounce", 3, V_IDLE);
    end
    raw_a = 1'b1;
    step("settle_wait", 10, V_IDLE);
    step("settle_rise", 1, V_A_RS);
    step("settle_hold", 1, V_A_HI);
    raw_a = 1'b0;
    step("settle_rel", 10, V_A_HI);
    step("settle_fall", 1, V_A_FL);
    step("settle_idle", 1, V_IDLE);

    // 4. Short glitch on B is rejected.
    raw_b = 1'b1;
    step("glitch_hi", 5, V_IDLE);
    raw_b = 1'b0;
    step("glitch_after", 15, V_IDLE);

    // 5. Simultaneous press on A and B, then A released alone, then B.
    raw_a = 1'b1;
    raw_b = 1'b1;
    step("sim_wait", 10, V_IDLE);
    step("sim_rise", 1, V_AB_RS);
    step("sim_hold", 1, V_AB_HI);
    raw_a = 1'b0;
    step("sim_a_wait", 10, V_AB_HI);
    step("sim_a_fall", 1, V_AF_BH);
    step("sim_a_idle", 1, V_B_HI);
    raw_b = 1'b0;
    step("sim_b_wait", 10, V_B_HI);
    step("sim_b_fall", 1, V_B_FL);
    step("sim_b_idle", 1, V_IDLE);

    // 6. Reset while channel A is counting in WAIT_HI with cnt=5.
    raw_a = 1'b1;
    step("mid_wait", 8, V_IDLE);
    check("mid_cnt_pre", {16'd0, dut.deb_a.cnt_q}, 32'd5);
    rst = 1'b1;
    step("mid_rst_edge", 1, V_IDLE);
    check("mid_cnt_rst", {16'd0, dut.deb_a.cnt_q}, 32'd0);
    rst = 1'b0;
    step("mid_rel_wait", 10, V_IDLE);
    step("mid_rel_rise", 1, V_A_RS);
    step("mid_rel_hold", 2, V_A_HI);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
